// File: rtl/seq_detect_frame_ctrl.sv
// Frame controller that serializes valid/ready words MSB-first onto a serial "0110" detector and counts hits per frame.
// Optional macro SEQ_CTRL_HITPOS_EN adds the first_hit_pos output.
module seq_detect_frame_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8,
  parameter int POS_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              det_clr,
  output logic              det_bit,
  input  logic              det_hit,
  output logic              frame_done,
  output logic [CNT_W-1:0]  frame_hits,
  output logic              frame_err,
`ifdef SEQ_CTRL_HITPOS_EN
  output logic [POS_W-1:0]  first_hit_pos,
`endif
  output logic [2:0]        dbg_state
);

  // Handshake: a word moves when s_valid && s_ready on a rising edge; s_ready never depends on s_valid.
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SHIFT = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] FLUSH = 3'd4;

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

  logic [2:0]        state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              shift_last_q, shift_last_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_last_q, hold_last_d;
  logic              hold_full_q, hold_full_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              bit_q, bit_d;

  logic hs, hit_ok, word_end, last_acc;

  assign hs       = s_valid && s_ready;
  assign hit_ok   = det_hit && bit_q;
  assign word_end = (state_q == SHIFT) && (bit_cnt_q == BC_LAST);
  assign last_acc = shift_last_q || (hold_full_q && hold_last_q);

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      IDLE, FLUSH: s_ready = reset;
      SHIFT:       s_ready = reset && !hold_full_q && !last_acc;
      default:     s_ready = 1'b0;
    endcase
  end

  // The detector is held clear whenever no frame is being shifted, including during reset.
  assign det_clr    = !reset || (state_q == IDLE) || (state_q == DONE) || (state_q == FLUSH);
  assign det_bit    = reset && (state_q == SHIFT) && shift_q[WORD_W-1];
  assign frame_done = reset && (state_q == DONE);
  assign frame_hits = cnt_q;
  assign frame_err  = err_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    shift_last_d = shift_last_q;
    hold_d       = hold_q;
    hold_last_d  = hold_last_q;
    hold_full_d  = hold_full_q;
    bit_cnt_d    = bit_cnt_q;
    pos_d        = pos_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    bit_d        = (state_q == SHIFT);

    if (hit_ok && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (hs) begin
          shift_d      = s_data;
          shift_last_d = s_last;
          bit_cnt_d    = '0;
          pos_d        = '0;
          cnt_d        = '0;
          err_d        = 1'b0;
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        pos_d     = (pos_q == '1) ? pos_q : pos_q + POS_W'(1);
        if (word_end) begin
          if (shift_last_q) begin
            state_d = DRAIN;
          end else if (hold_full_q) begin
            shift_d      = hold_q;
            shift_last_d = hold_last_q;
            hold_full_d  = 1'b0;
            bit_cnt_d    = '0;
          end else if (hs) begin
            shift_d      = s_data;
            shift_last_d = s_last;
            bit_cnt_d    = '0;
          end else begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end else if (hs) begin
          hold_d      = s_data;
          hold_last_d = s_last;
          hold_full_d = 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      DONE: begin
        hold_full_d = 1'b0;
        state_d     = (err_q && !last_acc) ? FLUSH : IDLE;
      end
      FLUSH: begin
        if (hs && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      shift_last_q <= 1'b0;
      hold_q       <= '0;
      hold_last_q  <= 1'b0;
      hold_full_q  <= 1'b0;
      bit_cnt_q    <= '0;
      pos_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      bit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      shift_last_q <= shift_last_d;
      hold_q       <= hold_d;
      hold_last_q  <= hold_last_d;
      hold_full_q  <= hold_full_d;
      bit_cnt_q    <= bit_cnt_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      bit_q        <= bit_d;
    end
  end

`ifdef SEQ_CTRL_HITPOS_EN
  // A hit reports the bit emitted in the previous cycle, hence pos_q - 1.
  logic [POS_W-1:0] first_pos_q, first_pos_d;

  always_comb begin
    first_pos_d = first_pos_q;
    if ((state_q == IDLE) && hs) first_pos_d = '1;
    else if (hit_ok && (cnt_q == '0)) first_pos_d = pos_q - POS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) first_pos_q <= '1;
    else        first_pos_q <= first_pos_d;
  end

  assign first_hit_pos = first_pos_q;
`endif

endmodule
